// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, FSM state encoding and command payload for alu_seq.
package alu_seq_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CMD_W  = 12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        EXEC = ST_EXEC,
        CAPT = ST_CAPT,
        RESP = ST_RESP
    } state_t;

    // Command payload; field order sets the 12-bit FIFO word layout.
    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic              load;
        logic              chain;
        logic [DATA_W-1:0] opnd;
    } cmd_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: synchronous first-word-fall-through FIFO with wrap-around pointers
// carrying one extra bit to tell full from empty. A push while full is dropped
// unless a pop happens in the same cycle.
module alu_seq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rptr[AW-1:0]];

    // Pointer update; the extra MSB toggles on each wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: command sequencer driving an external combinational ALU through
// IDLE -> EXEC -> CAPT -> RESP, keeping an 8-bit accumulator and a carry.
// Optional feature macro ALU_SEQ_FIFO_EN inserts a DEPTH-entry command FIFO
// ahead of the FSM; without it cmd_ready is high only in IDLE.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic              cmd_load,
    input  logic              cmd_chain,
    input  logic [DATA_W-1:0] cmd_opnd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_c,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_o,
    input  logic [DATA_W-1:0] alu_flag,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [DATA_W-1:0] res_flag,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    cmd_t              cmd_in;
    cmd_t              cmd;
    logic              cmd_avail;
    logic              take;
    logic              res_fire;
    logic [DATA_W-1:0] acc;
    logic              carry;

    assign cmd_in   = '{sel: cmd_sel, load: cmd_load, chain: cmd_chain, opnd: cmd_opnd};
    assign res_fire = res_valid && res_ready;

`ifdef ALU_SEQ_FIFO_EN
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_head;

    alu_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid && cmd_ready),
        .push_data (cmd_in),
        .pop       (take),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign cmd_avail = !fifo_empty;
    assign cmd       = cmd_t'(fifo_head);
`else
    logic unused_cfg;
    assign unused_cfg = ^DEPTH;

    // Ready mirrors "next state is IDLE", so it equals state==IDLE as a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cmd_ready <= 1'b1;
        else     cmd_ready <= (state_nxt == IDLE);
    end

    assign cmd_avail = cmd_valid && cmd_ready;
    assign cmd       = cmd_in;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and command take strobe.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_avail) begin
                    take      = 1'b1;
                    state_nxt = cmd.load ? RESP : EXEC;
                end
            end
            EXEC:    state_nxt = CAPT;
            CAPT:    state_nxt = RESP;
            RESP:    if (res_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: ALU drive, accumulator/carry, and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_c     <= 1'b0;
            alu_sel   <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            res_data  <= '0;
            res_flag  <= '0;
            res_valid <= 1'b0;
        end else begin
            if (take && !cmd.load) begin
                alu_a   <= acc;
                alu_b   <= cmd.opnd;
                alu_sel <= cmd.sel;
                alu_c   <= cmd.chain & carry;
            end
            if (take && cmd.load) begin
                acc      <= cmd.opnd;
                res_data <= cmd.opnd;
                res_flag <= '0;
            end
            if (state == CAPT) begin
                acc      <= alu_o;
                res_data <= alu_o;
                res_flag <= alu_flag;
                carry    <= alu_flag[0];
            end
            // Valid rises one cycle into RESP and drops on the transfer edge.
            if (state == RESP) res_valid <= !res_fire;
            else               res_valid <= 1'b0;
        end
    end

    // Busy flag registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= 1'b0;
        else     busy <= (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with an ALU stub, a command-level
// reference model (accumulator + carry + expected-result queue) and a compare
// process that checks every presented result. Honors ALU_SEQ_FIFO_EN.
module tb_alu_seq;

    localparam int unsigned DEPTH = 4;
`ifdef ALU_SEQ_FIFO_EN
    localparam int FIFO_LAT = 1;
`else
    localparam int FIFO_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_sel = 2'b00;
    logic       cmd_load = 1'b0;
    logic       cmd_chain = 1'b0;
    logic [7:0] cmd_opnd = 8'h00;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_c;
    logic [1:0] alu_sel;
    logic [7:0] alu_o;
    logic [7:0] alu_flag;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic [7:0] res_flag;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sel   (cmd_sel),
        .cmd_load  (cmd_load),
        .cmd_chain (cmd_chain),
        .cmd_opnd  (cmd_opnd),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .alu_sel   (alu_sel),
        .alu_o     (alu_o),
        .alu_flag  (alu_flag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_flag  (res_flag),
        .busy      (busy)
    );

    // ALU stub: 00 A+B+c, 01 A-B, 10 A&B, 11 A|B; flag[0] carry/borrow, flag[1] zero.
    logic [8:0] stub_sum;
    logic       stub_cy;
    always_comb begin
        stub_sum = 9'({1'b0, alu_a}) + 9'({1'b0, alu_b}) + 9'(alu_c);
        alu_o    = 8'h00;
        stub_cy  = 1'b0;
        case (alu_sel)
            2'b00: begin alu_o = stub_sum[7:0]; stub_cy = stub_sum[8]; end
            2'b01: begin alu_o = alu_a - alu_b; stub_cy = (alu_a < alu_b); end
            2'b10: alu_o = alu_a & alu_b;
            default: alu_o = alu_a | alu_b;
        endcase
        alu_flag = {6'b000000, (alu_o == 8'h00), stub_cy};
    end

    // Reference model at command level.
    typedef struct {
        logic [7:0] d;
        logic [7:0] f;
    } res_t;

    res_t       exp_q[$];
    logic [7:0] m_acc   = 8'h00;
    logic       m_carry = 1'b0;

    task automatic model_apply(input logic load, input logic [1:0] sel,
                               input logic chain, input logic [7:0] opnd);
        int   a = int'(m_acc);
        int   b = int'(opnd);
        int   r = 0;
        logic cy = 1'b0;
        res_t e;
        if (load) begin
            m_acc = opnd;
            e.d   = opnd;
            e.f   = 8'h00;
        end else begin
            case (sel)
                2'b00: begin r = a + b + ((chain && m_carry) ? 1 : 0); cy = (r > 255); end
                2'b01: begin r = a - b; cy = (a < b); end
                2'b10: r = a & b;
                default: r = a | b;
            endcase
            e.d     = 8'(r);
            e.f     = {6'b000000, (e.d == 8'h00), cy};
            m_acc   = e.d;
            m_carry = cy;
        end
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare every presented result against the model queue head.
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            check("busy_in_resp", 32'(busy), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_res_valid", 32'(res_data), 32'hFFFF_FFFF);
            end else begin
                check("res_data_model", 32'(res_data), 32'(exp_q[0].d));
                check("res_flag_model", 32'(res_flag), 32'(exp_q[0].f));
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cmd_drive(input logic load, input logic [1:0] sel,
                             input logic chain, input logic [7:0] opnd);
        cmd_load  = load;
        cmd_sel   = sel;
        cmd_chain = chain;
        cmd_opnd  = opnd;
        cmd_valid = 1'b1;
    endtask

    // Hold the driven command until accepted; returns the accept edge count.
    task automatic cmd_wait_accept(output int t0);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        check("cmd_accept_timeout", 32'(ok), 32'd1);
        if (ok) model_apply(cmd_load, cmd_sel, cmd_chain, cmd_opnd);
        cmd_valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_res(input int exp_lat, input int t0,
                            output logic [7:0] d, output logic [7:0] f);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = res_valid;
        end
        check("res_valid_timeout", 32'(seen), 32'd1);
        if (seen) check("latency", 32'(cyc - t0), 32'(exp_lat));
        d = res_data;
        f = res_flag;
    endtask

    // One complete command with res_ready high; result returned for literal checks.
    task automatic run_cmd(input logic load, input logic [1:0] sel, input logic chain,
                           input logic [7:0] opnd, output logic [7:0] d, output logic [7:0] f);
        logic [7:0] acc_before = m_acc;
        int t0;
        cmd_drive(load, sel, chain, opnd);
        cmd_wait_accept(t0);
        wait_res(load ? 1 + FIFO_LAT : 3 + FIFO_LAT, t0, d, f);
        if (!load) begin
            check("alu_a_hold", 32'(alu_a), 32'(acc_before));
            check("alu_b_hold", 32'(alu_b), 32'(opnd));
            check("alu_sel_hold", 32'(alu_sel), 32'(sel));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check({tag, "_alu_c"}, 32'(alu_c), 32'd0);
        check({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
        check({tag, "_res_data"}, 32'(res_data), 32'd0);
        check({tag, "_res_flag"}, 32'(res_flag), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] d;
        logic [7:0] f;
        int         t0;
        bit         drained;

        // Reset state.
        #1 rst = 1'b1;
        #2 check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // load 0x01, then 0x01 + 0x01.
        run_cmd(1'b1, 2'b00, 1'b0, 8'h01, d, f);
        check("load01_data", 32'(d), 32'h01);
        check("load01_flag", 32'(f), 32'h00);
        run_cmd(1'b0, 2'b00, 1'b0, 8'h01, d, f);
        check("add_0101_data", 32'(d), 32'h02);
        check("add_0101_cy", 32'(f[0]), 32'd0);

        // Wrap to 0x00 with carry, then chained add consumes the carry.
        run_cmd(1'b1, 2'b00, 1'b0, 8'hFF, d, f);
        run_cmd(1'b0, 2'b00, 1'b0, 8'h01, d, f);
        check("add_ff01_data", 32'(d), 32'h00);
        check("add_ff01_cy", 32'(f[0]), 32'd1);
        run_cmd(1'b0, 2'b00, 1'b1, 8'h00, d, f);
        check("chain_add_data", 32'(d), 32'h01);

        // Logic ops.
        run_cmd(1'b1, 2'b00, 1'b0, 8'h55, d, f);
        run_cmd(1'b0, 2'b10, 1'b0, 8'hAA, d, f);
        check("and_55aa_data", 32'(d), 32'h00);
        check("and_55aa_cy", 32'(f[0]), 32'd0);
        run_cmd(1'b0, 2'b11, 1'b0, 8'hAA, d, f);
        check("or_00aa_data", 32'(d), 32'hAA);

        // Subtract with borrow, chained add across 0xFF, load keeps carry.
        run_cmd(1'b1, 2'b00, 1'b0, 8'h01, d, f);
        run_cmd(1'b0, 2'b01, 1'b0, 8'h02, d, f);
        check("sub_0102_data", 32'(d), 32'hFF);
        check("sub_0102_borrow", 32'(f[0]), 32'd1);
        run_cmd(1'b0, 2'b00, 1'b1, 8'h00, d, f);
        check("chain_ff_data", 32'(d), 32'h00);
        check("chain_ff_cy", 32'(f[0]), 32'd1);
        run_cmd(1'b1, 2'b00, 1'b0, 8'h10, d, f);
        run_cmd(1'b0, 2'b00, 1'b1, 8'h00, d, f);
        check("load_keeps_carry", 32'(d), 32'h11);

        // Output stall with res_ready low for 10 cycles.
        res_ready = 1'b0;
        cmd_drive(1'b1, 2'b00, 1'b0, 8'h5A);
        cmd_wait_accept(t0);
        wait_res(1 + FIFO_LAT, t0, d, f);
        check("stall_load_data", 32'(d), 32'h5A);
`ifndef ALU_SEQ_FIFO_EN
        cmd_drive(1'b0, 2'b01, 1'b0, 8'h10);
`endif
        repeat (10) begin
            @(negedge clk);
            check("stall_res_valid", 32'(res_valid), 32'd1);
            check("stall_res_data", 32'(res_data), 32'h5A);
`ifndef ALU_SEQ_FIFO_EN
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
`endif
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
`ifndef ALU_SEQ_FIFO_EN
        cmd_wait_accept(t0);
        wait_res(3, t0, d, f);
        check("stalled_cmd_data", 32'(d), 32'h4A);
`endif
        @(posedge clk);
        #1;

        // Reset while the FSM sits in EXEC.
        cmd_drive(1'b0, 2'b11, 1'b0, 8'hF0);
        cmd_wait_accept(t0);
        if (FIFO_LAT != 0) begin
            @(posedge clk);
            #1;
        end
        check("exec_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("midreset");
        exp_q.delete();
        m_acc   = 8'h00;
        m_carry = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("no_valid_after_abort", 32'(res_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        run_cmd(1'b0, 2'b00, 1'b1, 8'h07, d, f);
        check("post_reset_acc0", 32'(d), 32'h07);
        check("post_reset_flag", 32'(f), 32'h00);

`ifdef ALU_SEQ_FIFO_EN
        // Five back-to-back commands with the result side stalled.
        res_ready = 1'b0;
        cmd_drive(1'b1, 2'b00, 1'b0, 8'h10);
        cmd_wait_accept(t0);
        repeat (4) begin
            cmd_drive(1'b0, 2'b00, 1'b0, 8'h01);
            cmd_wait_accept(t0);
        end
        @(negedge clk);
        check("fifo_full_ready", 32'(cmd_ready), 32'd0);
        check("fifo_model_last", 32'(exp_q[4].d), 32'h14);
        @(posedge clk);
        #1 res_ready = 1'b1;
`endif

        // Drain anything still expected.
        drained = 1'b0;
        for (int i = 0; i < 100 && !drained; i++) begin
            @(negedge clk);
            drained = (exp_q.size() == 0);
        end
        check("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
